// File: rtl/quiz_pkg.sv
// Shared constants and state encoding for the quiz round controller.
package quiz_pkg;

    localparam int N_PLAYER       = 4;
    localparam int SCORE_W        = 7;
    localparam int CLK_HZ_DEFAULT = 50_000_000;

    // One-hot state codes, driven straight onto the state output.
    localparam logic [3:0] ST_IDLE = 4'b0001;
    localparam logic [3:0] ST_RUN  = 4'b0010;
    localparam logic [3:0] ST_HOLD = 4'b0100;
    localparam logic [3:0] ST_DONE = 4'b1000;

    typedef enum logic [3:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_HOLD = ST_HOLD,
        S_DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter: first request at or after ptr wins.
module rr_arbiter4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [3:0] grant_oh,
    output logic [1:0] grant_idx
);

    logic [1:0] idx;
    logic       found;

    // Scan ptr, ptr+1, ... (mod 4) and take the first asserted request.
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && req[idx]) begin
                found         = 1'b1;
                grant_oh[idx] = 1'b1;
                grant_idx     = idx;
            end
        end
    end

endmodule

// File: rtl/quiz_round_ctrl.sv
// Round sequencer, buzzer arbiter, judge timeout and score keeper.
module quiz_round_ctrl
    import quiz_pkg::*;
#(
    parameter int CLK_HZ    = CLK_HZ_DEFAULT,
    parameter int ANS_SEC   = 5,
    parameter int POINTS    = 1,
    parameter int SCORE_MAX = 99
) (
    input  logic        sclk,
    input  logic        nrst,
    input  logic        key_start,
    input  logic [3:0]  key_buzz,
    input  logic        key_ok,
    input  logic        key_ng,
    input  logic        cnt_expire,
    output logic        cnt_pp,
    output logic        cnt_clr,
    output logic [3:0]  state,
    output logic [3:0]  winner,
    output logic [3:0]  lockout,
    output logic [27:0] score,
    output logic        buzz_en
);

    localparam int PRE_W = $clog2((CLK_HZ > 1) ? CLK_HZ : 2);
    localparam int SEC_W = $clog2((ANS_SEC + 1 > 2) ? ANS_SEC + 1 : 2);

    state_t                              state_q, state_d;
    logic [3:0]                          winner_q, winner_d;
    logic [3:0]                          lockout_q, lockout_d;
    logic [1:0]                          rr_ptr_q, rr_ptr_d;
    logic [1:0]                          win_idx_q, win_idx_d;
    logic [N_PLAYER-1:0][SCORE_W-1:0]    score_q, score_d;
    logic                                cnt_pp_q, cnt_pp_d;
    logic                                cnt_clr_q, cnt_clr_d;
    logic                                start_pend_q, start_pend_d;
    logic [PRE_W-1:0]                    pre_q;
    logic [SEC_W-1:0]                    sec_q;

    logic [3:0] req;
    logic [3:0] grant_oh;
    logic [1:0] grant_idx;
    logic [3:0] new_lock;
    logic       tick;
    logic       timeout;

    // Add POINTS one bit wider than the score so overflow is seen, then clamp.
    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] s);
        logic [SCORE_W:0] sum;
        sum = {1'b0, s} + (SCORE_W + 1)'(POINTS);
        if (sum > (SCORE_W + 1)'(SCORE_MAX))
            return SCORE_W'(SCORE_MAX);
        return sum[SCORE_W-1:0];
    endfunction

    assign req      = key_buzz & ~lockout_q;
    assign new_lock = lockout_q | winner_q;
    assign tick     = (pre_q == PRE_W'(CLK_HZ - 1));
    assign timeout  = tick && (sec_q == SEC_W'(ANS_SEC - 1));

    rr_arbiter4 u_arb (
        .req       (req),
        .ptr       (rr_ptr_q),
        .grant_oh  (grant_oh),
        .grant_idx (grant_idx)
    );

    // Next-state and next-output decode for the round FSM.
    always_comb begin
        state_d      = state_q;
        winner_d     = winner_q;
        lockout_d    = lockout_q;
        rr_ptr_d     = rr_ptr_q;
        win_idx_d    = win_idx_q;
        score_d      = score_q;
        cnt_pp_d     = start_pend_q;   // deferred "start countdown" pulse
        cnt_clr_d    = 1'b0;
        start_pend_d = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (key_start) begin
                    state_d      = S_RUN;
                    cnt_clr_d    = 1'b1;
                    lockout_d    = '0;
                    winner_d     = '0;
                    start_pend_d = 1'b1;
                end
            end
            S_RUN: begin
                if (cnt_expire) begin
                    state_d = S_DONE;
                end else if (|req) begin
                    winner_d  = grant_oh;
                    win_idx_d = grant_idx;
                    rr_ptr_d  = grant_idx + 2'd1;
                    // A grant on the very first RUN cycle would coincide with the
                    // start pulse; start and pause cancel so the countdown stays put.
                    cnt_pp_d  = ~start_pend_q;
                    state_d   = S_HOLD;
                end
            end
            S_HOLD: begin
                if (key_ok) begin
                    score_d[win_idx_q] = sat_add(score_q[win_idx_q]);
                    cnt_clr_d          = 1'b1;
                    state_d            = S_DONE;
                end else if (key_ng || timeout) begin
                    lockout_d = new_lock;
                    winner_d  = '0;
                    if (&new_lock) begin
                        cnt_clr_d = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        cnt_pp_d  = 1'b1;
                        state_d   = S_RUN;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM, grant, score and pulse registers.
    always_ff @(posedge sclk) begin
        if (!nrst) begin
            state_q      <= S_IDLE;
            winner_q     <= '0;
            lockout_q    <= '0;
            rr_ptr_q     <= '0;
            win_idx_q    <= '0;
            score_q      <= '0;
            cnt_pp_q     <= 1'b0;
            cnt_clr_q    <= 1'b0;
            start_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            winner_q     <= winner_d;
            lockout_q    <= lockout_d;
            rr_ptr_q     <= rr_ptr_d;
            win_idx_q    <= win_idx_d;
            score_q      <= score_d;
            cnt_pp_q     <= cnt_pp_d;
            cnt_clr_q    <= cnt_clr_d;
            start_pend_q <= start_pend_d;
        end
    end

    // Judge timer: runs only while staying in HOLD, zero everywhere else.
    always_ff @(posedge sclk) begin
        if (!nrst || state_q != S_HOLD || state_d != S_HOLD) begin
            pre_q <= '0;
            sec_q <= '0;
        end else if (tick) begin
            pre_q <= '0;
            sec_q <= sec_q + SEC_W'(1);
        end else begin
            pre_q <= pre_q + PRE_W'(1);
        end
    end

    assign state   = state_q;
    assign winner  = winner_q;
    assign lockout = lockout_q;
    assign score   = score_q;
    assign cnt_pp  = cnt_pp_q;
    assign cnt_clr = cnt_clr_q;
    assign buzz_en = (state_q == S_RUN);

endmodule

// File: doc/quiz_round_ctrl.md
Name: quiz_round_ctrl

Overview:
- Round sequencer and buzzer arbiter sitting above the countdown timer in the quiz/scoring design.
- Starts, pauses, resumes and clears the countdown.
- Grants one of four player buzz keys per answer slot, with round-robin tie-break, and runs a judge-response timeout.
- Keeps per-player saturating scores for the display/score logic.

Parameters:
- CLK_HZ, 50_000_000, sclk frequency; sets the 1 s tick.
- ANS_SEC, 5, seconds allowed for the judge to rule after a grant.
- POINTS, 1, points added per correct answer.
- SCORE_MAX, 99, score saturation value; fits in 7 bits.

Ports:
- sclk  in  1  system clock.
- nrst  in  1  reset; synchronous, active-low, sampled on posedge sclk.
- key_start  in  1  one-cycle pulse (debounced): start a round.
- key_buzz  in  4  one-cycle pulses, one bit per player, bit i = player i.
- key_ok  in  1  judge pulse: answer correct.
- key_ng  in  1  judge pulse: answer wrong.
- cnt_expire  in  1  one-cycle pulse from countdown: reached zero while playing.
- cnt_pp  out  1  one-cycle pulse to countdown pause/play input.
- cnt_clr  out  1  one-cycle pulse: countdown to STOP and reload start value.
- state  out  4  one-hot: IDLE=0001, RUN=0010, HOLD=0100, DONE=1000.
- winner  out  4  one-hot granted player; 0 when none.
- lockout  out  4  players locked out for the current round.
- score  out  28  packed 7-bit scores; player i at [7i+6:7i].
- buzz_en  out  1  high only in RUN.

Behaviour:
- Reset (nrst=0 at posedge): state=IDLE, winner=0, lockout=0, score=0, cnt_pp=0, cnt_clr=0, rr_ptr=0, answer timer=0. All outputs are registered; pulse outputs are exactly one cycle wide.
- IDLE or DONE, key_start:
  - Next cycle: cnt_clr=1, state=RUN, lockout=0, winner=0.
  - The cycle after that: cnt_pp=1 (start countdown).
  - key_start in RUN or HOLD is ignored.
- RUN:
  - Eligible requests: req = key_buzz & ~lockout.
  - If req != 0: grant the first set bit searching rr_ptr, rr_ptr+1, … mod 4. Register winner, set rr_ptr = granted index + 1 mod 4, pulse cnt_pp (pause), go to HOLD. Grant latency is 1 cycle.
  - cnt_expire wins over a same-cycle buzz: go to DONE with no grant and no cnt_pp.
- HOLD:
  - Answer timer counts 1 s ticks; timeout at ANS_SEC ticks.
  - key_ok (priority over a same-cycle key_ng): score[winner] += POINTS, saturating at SCORE_MAX. Then cnt_clr, go to DONE. winner is held until the next key_start.
  - key_ng, or timeout: lockout |= winner; winner=0.
    - If the new lockout is 4'b1111: cnt_clr, go to DONE.
    - Otherwise: cnt_pp (resume), go to RUN.
  - Buzzes are ignored (not queued).
  - cnt_expire in HOLD is impossible (countdown paused) and is ignored.
- DONE: countdown stopped or cleared. Scores persist across rounds; only nrst clears them.
- Answer timer: cycle prescaler 0..CLK_HZ-1 and second counter 0..ANS_SEC. Both clear on every HOLD entry and are held at 0 outside HOLD.
- Arithmetic: score add is done 1 bit wider, then clamped. score=98 with POINTS=5 gives 99.
- Reset mid-round: immediate return to reset values. No cnt_pp or cnt_clr is issued on reset; the countdown has its own reset.

Decomposition:
- Shared package quiz_pkg holds:
  - state localparams ST_IDLE/ST_RUN/ST_HOLD/ST_DONE;
  - N_PLAYER=4, SCORE_W=7;
  - the default CLK_HZ.
- One sub-module, rr_arbiter4: inputs req[3:0] and ptr[1:0]; outputs combinational grant_oh[3:0] and grant_idx[1:0].
- FSM, timer and score registers stay in the top level.

Test Plan:
- key_start from IDLE → cnt_clr at T+1, cnt_pp at T+2, state=RUN, buzz_en=1.
- RUN with rr_ptr=0, key_buzz=4'b1010 → winner=0010, cnt_pp one cycle, state=HOLD, rr_ptr=2. A later tie 4'b1010 → winner=1000.
- HOLD then key_ok, score1=98, POINTS=5 → score1=99, cnt_clr, state=DONE. key_ok and key_ng in the same cycle → treated as ok.
- HOLD with ANS_SEC=2, CLK_HZ=10 and no judge input → after 20 cycles lockout=0010, cnt_pp, state=RUN. A buzz from player 1 is then ignored.
- key_ng on all four players in turn → lockout=1111, cnt_clr, state=DONE, scores unchanged.
- RUN: cnt_expire with key_buzz=0001 in the same cycle → state=DONE, winner=0. Assert nrst=0 mid-HOLD → all outputs at reset values next edge.
